// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled digit select, frame-boundary shadowing, anti-ghost gap.
// Optional decimal-point support is compiled in when SEG_SCAN_DP_EN is defined.
module seg_scan_ctrl #(
  parameter int DIGITS = 8,
  parameter int DIV    = 2500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  freeze,
`ifdef SEG_SCAN_DP_EN
  input  logic [DIGITS-1:0]     dp,
`endif
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_start
);

  localparam int SEL_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRESC_W = $clog2(DIV);
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(DIGITS - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0]  presc;
  logic [SEL_W-1:0]    sel;
  logic [4*DIGITS-1:0] shadow_data;
  logic [DIGITS-1:0]   shadow_blank;
  logic                tick;
  logic                boundary;
  logic [3:0]          nibble;
  logic                digit_blank;
  logic                digit_dp;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   an_next;
  logic [7:0]          seg_next;

  assign tick     = (presc == PRESC_LAST);
  assign boundary = tick && (sel == SEL_LAST);

`ifdef SEG_SCAN_DP_EN
  logic [DIGITS-1:0] shadow_dp;

  always_ff @(posedge clk) begin
    if (!rst)
      shadow_dp <= '0;
    else if (boundary && !freeze)
      shadow_dp <= dp;
  end
`endif

  // Select the shadowed attributes of the digit currently being scanned.
  always_comb begin
    nibble      = '0;
    digit_blank = 1'b1;
    digit_dp    = 1'b0;
    an_next     = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == SEL_W'(i)) begin
        nibble      = shadow_data[4*i +: 4];
        digit_blank = shadow_blank[i];
`ifdef SEG_SCAN_DP_EN
        digit_dp    = shadow_dp[i];
`endif
        an_next[i]  = shadow_blank[i];
      end
    end
  end

  always_comb begin
    case (nibble)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    seg_next = digit_blank ? 8'hFF : {~digit_dp, glyph};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc        <= '0;
      sel          <= '0;
      an           <= '1;
      seg          <= 8'hFF;
      frame_start  <= 1'b0;
      shadow_data  <= '0;
      // NOTE: shadows reset to blanked so the display stays dark until a real frame is captured.
      shadow_blank <= '1;
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      frame_start <= boundary;
      if (tick)
        sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
      if (boundary && !freeze) begin
        shadow_data  <= data;
        shadow_blank <= blank;
      end
      // The cycle after each tick is a dark gap so the previous digit never ghosts onto the next.
      if (tick) begin
        an  <= '1;
        seg <= 8'hFF;
      end else begin
        an  <= an_next;
        seg <= seg_next;
      end
    end
  end

endmodule
